// File: rtl/fn_logic_pipe.sv
// rtl/fn_logic_pipe.sv - pipelined AND/OR/XOR/XNOR logic lane with valid/ready handshake and zero flag (optional LOGIC_PARITY_EN adds a parity output)
module fn_logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
`ifdef LOGIC_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    logic [WIDTH-1:0] result;

    // Stage registers: only the finished result and its valid bit travel down the pipe.
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  dat_q [STAGES];

    // Upstream view of each stage: stage 0 sees the operand port, stage k sees stage k-1.
    logic [STAGES-1:0] up_vld;
    logic [WIDTH-1:0]  up_dat [STAGES];

    // rdy[k] says stage k may load this cycle; rdy[STAGES] is the consumer.
    logic [STAGES:0]   rdy;

    // Bitwise function select; every bit is independent so no carry logic is needed.
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            default: result = '0;
        endcase
    end

    // Wire each stage to the one feeding it.
    always_comb begin
        up_vld[0] = in_valid;
        up_dat[0] = result;
        for (int k = 1; k < STAGES; k++) begin
            up_vld[k] = vld_q[k-1];
            up_dat[k] = dat_q[k-1];
        end
    end

    // Combinational ready chain from the output back to the input; an empty stage
    // is always ready, so bubbles collapse even while the consumer stalls.
    always_comb begin
        logic r;
        r = out_ready;
        rdy = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r = !vld_q[k] || r;
            rdy[k] = r;
        end
    end

    // Elastic stage update: load from upstream when ready, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= up_vld[k];
                    dat_q[k] <= up_dat[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[STAGES-1];
    assign y         = dat_q[STAGES-1];
    assign zero      = (dat_q[STAGES-1] == '0);

`ifdef LOGIC_PARITY_EN
    logic [STAGES-1:0] par_q;
    logic [STAGES-1:0] up_par;

    // Parity of the result rides alongside the data.
    always_comb begin
        up_par[0] = ^result;
        for (int k = 1; k < STAGES; k++) begin
            up_par[k] = par_q[k-1];
        end
    end

    // Parity stages follow exactly the same load/hold/reset rules as the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    par_q[k] <= up_par[k];
                end
            end
        end
    end

    assign parity = par_q[STAGES-1];
`endif

endmodule
